// File: rtl/cpu_pkg.sv
// Shared hazard-control types: forwarding-select codes and the hazard FSM state encoding.
package cpu_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_MEM  = 2'b11;

    typedef enum logic {
        HZ_RUN,
        HZ_LOAD_STALL
    } hz_state_t;

endpackage

// File: rtl/fwd_match.sv
// Forwarding select for one EX-stage source operand; the younger MEM result beats WB.
module fwd_match
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_wb_reg_write,
    output logic [1:0]            o_fwd
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    assign w_mem_hit = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_src);
    assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_src);

    always_comb begin
        o_fwd = FWD_NONE;
        if (w_mem_hit) begin
            o_fwd = FWD_MEM;
        end else if (w_wb_hit) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubbles, branch flushes, memory-wait freeze.
// Define HAZARD_PERF_CNT_EN to add the load-stall and branch-flush performance counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_STALL_N = 1,
    parameter int FLUSH_DEPTH  = 3,
    parameter int PERF_CNT_W   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_enable,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] i_ex_rs,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_mem_reg_write,
    input  logic                  i_wb_reg_write,
    input  logic                  i_branch_taken,
    input  logic                  i_mem_busy,
    output logic [1:0]            o_fwd_rs,
    output logic [1:0]            o_fwd_rt,
    output logic                  o_pc_en,
    output logic                  o_ifid_en,
    output logic                  o_idex_en,
    output logic                  o_exmem_en,
    output logic                  o_memwb_en,
    output logic                  o_ifid_flush,
    output logic                  o_idex_flush,
    output logic                  o_exmem_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] o_stall_cnt,
    output logic [PERF_CNT_W-1:0] o_flush_cnt
`endif
);

    hz_state_t       r_state;
    hz_state_t       w_state_nxt;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_nxt;
    logic [1:0]      w_fwd_rs;
    logic [1:0]      w_fwd_rt;
    logic            w_load_use;
    logic            w_bubble;
    logic            w_pc_en;
    logic            w_ifid_en;
    logic            w_idex_en;
    logic            w_exmem_en;
    logic            w_memwb_en;
    logic            w_ifid_flush;
    logic            w_idex_flush;
    logic            w_exmem_flush;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .i_src           (i_ex_rs),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .i_wb_rd         (i_wb_rd),
        .i_wb_reg_write  (i_wb_reg_write),
        .o_fwd           (w_fwd_rs)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .i_src           (i_ex_rt),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .i_wb_rd         (i_wb_rd),
        .i_wb_reg_write  (i_wb_reg_write),
        .o_fwd           (w_fwd_rt)
    );

    assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                        ((i_id_uses_rs && (i_ex_rd == i_id_rs)) ||
                         (i_id_uses_rt && (i_ex_rd == i_id_rt)));

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= HZ_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A frozen cycle (disabled or memory wait) keeps state and count untouched so a stall resumes exactly.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bubble      = 1'b0;
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        if (!i_enable || i_mem_busy) begin
            w_state_nxt = r_state;
        end else if (i_branch_taken) begin
            w_pc_en       = 1'b1;
            w_ifid_en     = 1'b1;
            w_idex_en     = 1'b1;
            w_exmem_en    = 1'b1;
            w_memwb_en    = 1'b1;
            w_ifid_flush  = (FLUSH_DEPTH >= 1);
            w_idex_flush  = (FLUSH_DEPTH >= 2);
            w_exmem_flush = (FLUSH_DEPTH >= 3);
            w_state_nxt   = HZ_RUN;
            w_cnt_nxt     = 3'd0;
        end else if (r_state == HZ_LOAD_STALL) begin
            w_bubble = 1'b1;
            if (r_cnt <= 3'd1) begin
                w_state_nxt = HZ_RUN;
                w_cnt_nxt   = 3'd0;
            end else begin
                w_cnt_nxt = r_cnt - 3'd1;
            end
        end else if (w_load_use) begin
            w_bubble = 1'b1;
            if (LOAD_STALL_N > 1) begin
                w_state_nxt = HZ_LOAD_STALL;
                w_cnt_nxt   = 3'(LOAD_STALL_N - 1);
            end
        end else begin
            w_pc_en    = 1'b1;
            w_ifid_en  = 1'b1;
            w_idex_en  = 1'b1;
            w_exmem_en = 1'b1;
            w_memwb_en = 1'b1;
        end
        if (w_bubble) begin
            w_idex_en    = 1'b1;
            w_exmem_en   = 1'b1;
            w_memwb_en   = 1'b1;
            w_idex_flush = 1'b1;
        end
    end

    // Reset forces every control output low regardless of the combinational state.
    assign o_fwd_rs      = i_arst_n ? w_fwd_rs : FWD_NONE;
    assign o_fwd_rt      = i_arst_n ? w_fwd_rt : FWD_NONE;
    assign o_pc_en       = i_arst_n & w_pc_en;
    assign o_ifid_en     = i_arst_n & w_ifid_en;
    assign o_idex_en     = i_arst_n & w_idex_en;
    assign o_exmem_en    = i_arst_n & w_exmem_en;
    assign o_memwb_en    = i_arst_n & w_memwb_en;
    assign o_ifid_flush  = i_arst_n & w_ifid_flush;
    assign o_idex_flush  = i_arst_n & w_idex_flush;
    assign o_exmem_flush = i_arst_n & w_exmem_flush;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] r_stall_cnt;
    logic [PERF_CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_enable && !i_mem_busy) begin
            if (w_bubble) begin
                r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
            end
            if (i_branch_taken) begin
                r_flush_cnt <= r_flush_cnt + PERF_CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    logic w_unused_perf_cfg;
    assign w_unused_perf_cfg = (PERF_CNT_W != 0);
`endif

endmodule
